// File: rtl/noc_pkg.sv
// Shared router definitions: flit width, port numbering and arbiter FSM encodings.
package noc_pkg;

    localparam int unsigned FLIT_W    = 32;
    localparam int unsigned NUM_PORTS = 5;

    localparam int unsigned PORT_L = 0;
    localparam int unsigned PORT_N = 1;
    localparam int unsigned PORT_E = 2;
    localparam int unsigned PORT_S = 3;
    localparam int unsigned PORT_W = 4;

    typedef logic [FLIT_W-1:0] flit_t;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin select: first requester at or after ptr, wrapping modulo NUM_REQ.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 5,
    parameter int unsigned IDX_W   = 3
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] onehot,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);

    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] pos;

    // ptr is always < NUM_REQ, so a single subtraction performs the wrap
    always_comb begin
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        sum    = '0;
        pos    = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            sum = {1'b0, ptr} + (IDX_W+1)'(k);
            if (sum >= (IDX_W+1)'(NUM_REQ)) begin
                sum = sum - (IDX_W+1)'(NUM_REQ);
            end
            pos = sum[IDX_W-1:0];
            if (!any && req[pos]) begin
                any         = 1'b1;
                idx         = pos;
                onehot[pos] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/output_port_arbiter.sv
// Output channel arbiter: round-robin grant locked from head to tail flit, stalled by ret.
module output_port_arbiter #(
    parameter int unsigned NUM_REQ = noc_pkg::NUM_PORTS,
    parameter int unsigned FLIT_W  = noc_pkg::FLIT_W,
    parameter int unsigned IDX_W   = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        tail,
    input  logic [NUM_REQ*FLIT_W-1:0] flit_in,
    input  logic                      ret,
    output logic [NUM_REQ-1:0]        rd_en,
    output logic [NUM_REQ-1:0]        grant,
    output logic                      free,
    output logic [FLIT_W-1:0]         flit_out,
    output logic                      busy
);

    noc_pkg::state_t    state_q, state_d;
    logic [IDX_W-1:0]   gidx_q, gidx_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [NUM_REQ-1:0] grant_d;
    logic               free_d;
    logic [FLIT_W-1:0]  flit_d;

    logic [NUM_REQ-1:0] arb_onehot;
    logic [IDX_W-1:0]   arb_idx;
    logic               arb_any;
    logic               xfer;
    logic [FLIT_W-1:0]  flit_arr [NUM_REQ];

    for (genvar i = 0; i < int'(NUM_REQ); i++) begin : g_unpack
        assign flit_arr[i] = flit_in[i*FLIT_W +: FLIT_W];
    end

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_arbiter (
        .req    (req),
        .ptr    (rr_ptr_q),
        .onehot (arb_onehot),
        .idx    (arb_idx),
        .any    (arb_any)
    );

    assign xfer = (state_q == noc_pkg::ST_ACTIVE) && req[gidx_q] && !ret;
    assign busy = (state_q == noc_pkg::ST_ACTIVE);

    // Next-state, pop strobe and output-register next values
    always_comb begin
        state_d  = state_q;
        grant_d  = grant;
        gidx_d   = gidx_q;
        rr_ptr_d = rr_ptr_q;
        free_d   = 1'b0;
        flit_d   = flit_out;
        rd_en    = '0;
        case (state_q)
            noc_pkg::ST_IDLE: begin
                if (arb_any) begin
                    grant_d = arb_onehot;
                    gidx_d  = arb_idx;
                    state_d = noc_pkg::ST_ACTIVE;
                end
            end
            noc_pkg::ST_ACTIVE: begin
                if (xfer) begin
                    rd_en  = grant;
                    free_d = 1'b1;
                    flit_d = flit_arr[gidx_q];
                    if (tail[gidx_q]) begin
                        state_d  = noc_pkg::ST_IDLE;
                        grant_d  = '0;
                        rr_ptr_d = (gidx_q == IDX_W'(NUM_REQ-1)) ? '0 : gidx_q + IDX_W'(1);
                    end
                end
            end
            default: state_d = noc_pkg::ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= noc_pkg::ST_IDLE;
            grant    <= '0;
            gidx_q   <= '0;
            rr_ptr_q <= '0;
            free     <= 1'b0;
            flit_out <= '0;
        end else begin
            state_q  <= state_d;
            grant    <= grant_d;
            gidx_q   <= gidx_d;
            rr_ptr_q <= rr_ptr_d;
            free     <= free_d;
            flit_out <= flit_d;
        end
    end

endmodule

// File: doc/output_port_arbiter.md
Name: output_port_arbiter

Overview:
- Shares one router output channel between NUM_REQ input ports (N, E, S, W, Local by default), using round-robin arbitration.
- A grant is locked from the head flit through the tail flit. It is released only when the tail flit has been transferred.
- Flits move only while the downstream input buffer is not full (ret=0).
- The block drives free/flit toward output_flow_control, which maps free to val and passes ret back.

Parameters:
- NUM_REQ, 5, number of requesting input ports (index 0=Local, 1=N, 2=E, 3=S, 4=W).
- FLIT_W, 32, flit width in bits.
- IDX_W, 3, width of grant index; must satisfy 2**IDX_W >= NUM_REQ.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- req  in  NUM_REQ  port i has a flit routed to this output at its buffer head (level, = buffer non-empty and route match).
- tail  in  NUM_REQ  flit currently offered by port i is a tail flit; qualified by req[i].
- flit_in  in  NUM_REQ*FLIT_W  concatenated head-of-buffer flits, port i at bits [i*FLIT_W +: FLIT_W].
- ret  in  1  neighbour input buffer full; 1 = stall.
- rd_en  out  NUM_REQ  one-hot pop strobe to input buffer i (combinational).
- grant  out  NUM_REQ  one-hot registered ownership of the output.
- free  out  1  registered; 1 = flit_out valid this cycle (to output_flow_control.free).
- flit_out  out  FLIT_W  registered flit toward neighbour.
- busy  out  1  1 while FSM in ACTIVE.

Behaviour:
- Reset (async, rst_n=0):
  - grant=0, free=0, flit_out=0, busy=0.
  - state=IDLE, rr_ptr=0.
  - rd_en=0, because it is gated by grant.
- FSM with states IDLE and ACTIVE.
- IDLE:
  - If |req, select the first i with req[i]=1, searching i = rr_ptr, rr_ptr+1, ..., wrapping modulo NUM_REQ.
  - Register grant=onehot(i), gidx=i, and go to ACTIVE.
  - No flit moves in the arbitration cycle.
- ACTIVE:
  - A transfer occurs in a cycle when req[gidx]=1 and ret=0.
  - In that cycle, rd_en[gidx]=1 (combinational), flit_out<=flit_in[gidx], and free<=1 in the next cycle.
  - In any other cycle, rd_en=0 and free<=0. flit_out holds its last value.
- Release:
  - Applies on a transfer with tail[gidx]=1.
  - Next state is IDLE, grant<=0, and rr_ptr<=(gidx+1) mod NUM_REQ.
  - The last flit's free=1 appears in the same cycle as grant=0.
- Latency: req rise in IDLE at cycle 0 -> grant at cycle 1 -> rd_en at cycle 1 (if ret=0) -> free/flit_out at cycle 2.
- Throughput: one flit per cycle while req[gidx]=1 and ret=0.
- After each packet there is one idle arbitration cycle, so back-to-back packets have a 1-cycle bubble.
- Boundary conditions:
  - ret=1 mid-packet: grant held, rd_en=0, free=0 from the next cycle; the packet resumes when ret falls.
  - req[gidx]=0 mid-packet (input buffer momentarily empty): grant held, no transfer. Other ports' req are ignored until the tail transfers.
  - Single-flit packet (head and tail are the same flit): ACTIVE lasts 1 cycle if ret=0.
  - Requests from non-granted ports never see rd_en.
  - rd_en is always one-hot or zero.
  - A tail flit on a cycle with ret=1 does not release the grant.
  - Simultaneous requests from all ports are served in order rr_ptr, rr_ptr+1, ..., which gives starvation freedom.
  - The rr_ptr wrap from NUM_REQ-1 to 0 is required.
  - Reset mid-packet: all state cleared immediately. Upstream buffers are not popped further, and the partial packet is the system's responsibility.
  - req bits beyond NUM_REQ do not exist; unused gidx codes are unreachable.

Decomposition:
- Shared package/header noc_pkg:
  - FLIT_W.
  - Port index constants (PORT_L=0, PORT_N=1, PORT_E=2, PORT_S=3, PORT_W=4).
  - NUM_PORTS=5.
  - FSM state encodings ST_IDLE=1'b0, ST_ACTIVE=1'b1.
- One sub-module, rr_arbiter: combinational round-robin select.
  - Inputs: req and ptr.
  - Outputs: onehot grant, index, and any.
  - Instantiated once; output_port_arbiter owns the FSM, pointer, mux and output registers.

Test Plan:
- Reset behaviour: rst_n=0 asserted mid-packet (3 of 5 flits sent) -> grant, free and busy are 0 within the same cycle, with no clock edge needed. After release, the first request from port 0 is granted first (rr_ptr=0).
- Single requester: req[1]=1 with a 4-flit packet 0xA1..0xA4, tail on the 4th, ret=0 -> grant=5'b00010 at c1, rd_en[1] at c1..c4, free=1 with flit_out 0xA1..0xA4 at c2..c5, grant=0 at c5.
- Round robin: all req=5'b11111 with 1-flit packets, re-requested continuously -> grant order 0,1,2,3,4,0, each 2 cycles apart.
- Backpressure: 3-flit packet from port 2, ret=1 for cycles 3..5 -> rd_en[2]=0 and free=0 during the stall, no flit lost or duplicated, output sequence intact, grant held throughout.
- Lock: port 3 is mid-packet while port 4 raises req and port 3's req drops for 2 cycles -> grant stays 5'b01000, rd_en[4] never asserts, and port 4 is granted only in the cycle after port 3's tail transfers.
- Tail under stall: tail offered by the granted port with ret=1 -> no release; release occurs on the cycle ret=0. rr_ptr then advances to gidx+1, checked by the next grant with req=5'b11111.
